// File: rtl/mem_access_if.sv
// Bundled request/response and word-RAM bus signals of the load/store front end.
// The unit uses the slave modport; the CPU datapath and RAM side use master.
interface mem_access_if #(
    parameter int ADDR_W = 12
);
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [1:0]          req_size;
    logic                req_signed;
    logic [ADDR_W+1:0]   req_addr;
    logic [31:0]         req_wdata;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_rdata;
    logic                resp_err;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [3:0]          mem_byteenable;
    logic [31:0]         mem_writedata;
    logic [31:0]         mem_readdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end driving a 32-bit word RAM.
// Optional `MEM_ALIGN_CHECK_EN rejects misaligned and size-11 requests with resp_err.
module mem_access_unit #(
    parameter int ADDR_W = 12
) (
    input logic         clk,
    input logic         reset_n,
    mem_access_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [3:0]        mem_byteenable_q;
    logic [31:0]       mem_writedata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic [1:0]        eff_size;
    logic              req_err;
    logic [3:0]        be_next;
    logic [31:0]       wd_next;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    // Size 11 behaves as a word whenever it is not rejected outright.
    assign eff_size = (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        req_err = 1'b0;
        case (bus.req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = bus.req_addr[0];
            SZ_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end
`else
    assign req_err = 1'b0;
`endif

    always_comb begin
        be_next = 4'b1111;
        wd_next = bus.req_wdata;
        case (eff_size)
            SZ_BYTE: begin
                be_next = 4'b0001 << bus.req_addr[1:0];
                wd_next = {4{bus.req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_next = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset captured at acceptance; mem_readdata is live in WAIT.
    assign rd_byte = bus.mem_readdata[{lane_q, 3'b000} +: 8];
    assign rd_half = lane_q[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];

    always_comb begin
        load_data = bus.mem_readdata;
        case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_data = {{16{signed_q & rd_half[15]}}, rd_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            write_q          <= 1'b0;
            size_q           <= SZ_BYTE;
            signed_q         <= 1'b0;
            lane_q           <= 2'b00;
            mem_address_q    <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_byteenable_q <= 4'b0000;
            mem_writedata_q  <= 32'h0;
            resp_rdata_q     <= 32'h0;
            resp_err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q  <= bus.req_write;
                        size_q   <= eff_size;
                        signed_q <= bus.req_signed;
                        lane_q   <= bus.req_addr[1:0];
                        if (req_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            state        <= RESP;
                        end else begin
                            mem_address_q    <= bus.req_addr[ADDR_W+1:2];
                            mem_byteenable_q <= be_next;
                            mem_writedata_q  <= wd_next;
                            mem_read_q       <= ~bus.req_write;
                            mem_write_q      <= bus.req_write;
                            state            <= ACCESS;
                        end
                    end
                end
                ACCESS: state <= write_q ? RESP : WAIT;
                WAIT: begin
                    resp_rdata_q <= load_data;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_byteenable = mem_byteenable_q;
    assign bus.mem_writedata  = mem_writedata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word RAM, transaction-level reference model, per-cycle compare,
// and directed loads/stores with literal expectations.
module tb_mem_access_unit;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word RAM: write commits at the strobe edge, read data appears the cycle after mem_read.
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_write)
            for (int b = 0; b < 4; b++)
                if (bus.mem_byteenable[b])
                    ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
        if (bus.mem_read)
            bus.mem_readdata <= ram[bus.mem_address];
    end

    // Reference model: byte-addressed memory plus an expected timeline per request.
    logic [7:0] ref_mem [int];
    bit          m_busy = 1'b0;
    int          m_cyc, m_lat, m_base, m_nb;
    logic        m_write, m_err;
    logic [3:0]  m_be;
    logic [31:0] m_wd, m_wdata, m_rdata;
    logic [ADDR_W-1:0] m_word;

    function automatic logic [7:0] rb(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic model_accept();
        int a;
        logic [31:0] v;
        a = int'(bus.req_addr);
        m_err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        m_err = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && a % 2 != 0) ||
                (bus.req_size == 2'b10 && a % 4 != 0);
`endif
        m_nb    = (bus.req_size == 2'b00) ? 1 : (bus.req_size == 2'b01) ? 2 : 4;
        m_base  = a - (a % m_nb);
        m_word  = ADDR_W'(m_base / 4);
        m_write = bus.req_write;
        m_wdata = bus.req_wdata;
        m_be    = 4'b0000;
        for (int i = 0; i < m_nb; i++) m_be[(m_base % 4) + i] = 1'b1;
        for (int l = 0; l < 4; l++) m_wd[8*l +: 8] = m_wdata[8*(l % m_nb) +: 8];
        v = 32'h0;
        for (int i = 0; i < m_nb; i++) v[8*i +: 8] = rb(m_base + i);
        if (bus.req_signed && m_nb < 4 && v[8*m_nb-1]) v = v | (32'hFFFF_FFFF << (8*m_nb));
        m_rdata = (m_write || m_err) ? 32'h0 : v;
        m_lat   = m_err ? 1 : (m_write ? 2 : 3);
        m_cyc   = 1;
        m_busy  = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_cyc >= m_lat && bus.resp_ready) begin
                m_busy = 1'b0;
            end else begin
                if (m_cyc == 1 && m_write && !m_err)
                    for (int i = 0; i < m_nb; i++) ref_mem[m_base + i] = m_wdata[8*i +: 8];
                m_cyc++;
            end
        end else if (bus.req_valid) begin
            model_accept();
        end
    end

    // Observations for the directed literal checks.
    int          strobe_cnt;
    logic [ADDR_W-1:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd, obs_rdata;
    logic        obs_err;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_req_ready", bus.req_ready, 1'b1);
            check("rst_resp_valid", bus.resp_valid, 1'b0);
            check("rst_mem_read", bus.mem_read, 1'b0);
            check("rst_mem_write", bus.mem_write, 1'b0);
            check("rst_mem_be", bus.mem_byteenable, 4'b0000);
            check("rst_mem_address", bus.mem_address, '0);
            check("rst_mem_wdata", bus.mem_writedata, 32'h0);
            check("rst_resp_rdata", bus.resp_rdata, 32'h0);
            check("rst_resp_err", bus.resp_err, 1'b0);
        end else begin
            check("req_ready", bus.req_ready, !m_busy);
            check("resp_valid", bus.resp_valid, m_busy && m_cyc >= m_lat);
            check("mem_read", bus.mem_read, m_busy && m_cyc == 1 && !m_write && !m_err);
            check("mem_write", bus.mem_write, m_busy && m_cyc == 1 && m_write && !m_err);
            if (m_busy && m_cyc == 1 && !m_err) begin
                check("mem_address", bus.mem_address, m_word);
                check("mem_byteenable", bus.mem_byteenable, m_be);
                if (m_write) check("mem_writedata", bus.mem_writedata, m_wd);
            end
            if (m_busy && m_cyc >= m_lat) begin
                check("resp_rdata", bus.resp_rdata, m_rdata);
                check("resp_err", bus.resp_err, m_err);
            end
            if (bus.mem_read || bus.mem_write) begin
                strobe_cnt++;
                obs_addr = bus.mem_address;
                obs_be   = bus.mem_byteenable;
                obs_wd   = bus.mem_writedata;
            end
        end
    end

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // One request; returns cycles from acceptance to first resp_valid.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [ADDR_W+1:0] addr, input logic [31:0] wd,
                          input int hold, output int lat);
        int k;
        strobe_cnt = 0;
        obs_be = 4'h0; obs_wd = 32'h0; obs_addr = '0;
        bus.resp_ready = (hold == 0);
        @(negedge clk);
        k = 0;
        while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
        if (!bus.req_ready) timeout("req_ready");
        #1;
        bus.req_write = wr; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) timeout("resp_valid");
        obs_rdata = bus.resp_rdata;
        obs_err   = bus.resp_err;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            #1 bus.resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int word, input logic [31:0] val);
        ram[word] = val;
        for (int i = 0; i < 4; i++) ref_mem[4*word + i] = val[8*i +: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'h0;
        bus.resp_ready = 1'b1; bus.mem_readdata = 32'h0;

        repeat (3) @(negedge clk);
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_mem_be", bus.mem_byteenable, 4'b0000);
        #1 reset_n = 1'b1;

        // Word store then word load at 0x010.
        do_req(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEAD_BEEF, 0, lat);
        check("st_word_lat", lat, 2);
        check("st_word_be", obs_be, 4'b1111);
        check("st_word_addr", obs_addr, 12'd4);
        check("st_word_wd", obs_wd, 32'hDEAD_BEEF);
        check("st_word_rdata", obs_rdata, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 0, lat);
        check("ld_word_lat", lat, 3);
        check("ld_word_rdata", obs_rdata, 32'hDEAD_BEEF);

        // Byte store of 0x80 at the top lane, then signed/unsigned byte loads.
        do_req(1'b1, 2'b00, 1'b0, 14'h013, 32'h0000_0080, 0, lat);
        check("st_byte_be", obs_be, 4'b1000);
        check("st_byte_wd", obs_wd, 32'h8080_8080);
        do_req(1'b0, 2'b00, 1'b1, 14'h013, 32'h0, 0, lat);
        check("ld_sbyte", obs_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 14'h013, 32'h0, 0, lat);
        check("ld_ubyte", obs_rdata, 32'h0000_0080);
        do_req(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 0, lat);
        check("ld_word_merged", obs_rdata, 32'h80AD_BEEF);

        // Halfword and byte extraction from a preloaded word.
        preload(4, 32'h8001_1234);
        do_req(1'b0, 2'b01, 1'b1, 14'h012, 32'h0, 0, lat);
        check("ld_shalf_be", obs_be, 4'b1100);
        check("ld_shalf", obs_rdata, 32'hFFFF_8001);
        do_req(1'b0, 2'b01, 1'b0, 14'h010, 32'h0, 0, lat);
        check("ld_uhalf_be", obs_be, 4'b0011);
        check("ld_uhalf_lo", obs_rdata, 32'h0000_1234);
        do_req(1'b0, 2'b00, 1'b1, 14'h011, 32'h0, 0, lat);
        check("ld_sbyte_pos", obs_rdata, 32'h0000_0012);

        // Response back-pressure: five extra cycles with resp_ready low.
        do_req(1'b0, 2'b01, 1'b0, 14'h012, 32'h0, 5, lat);
        check("hold_rdata", obs_rdata, 32'h0000_8001);
        check("hold_strobes", strobe_cnt, 1);

        // Misaligned word and size-11 requests.
        do_req(1'b0, 2'b10, 1'b0, 14'h011, 32'h0, 0, lat);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_lat", lat, 1);
        check("mis_strobes", strobe_cnt, 0);
        check("mis_err", obs_err, 1'b1);
        check("mis_rdata", obs_rdata, 32'h0);
`else
        check("mis_lat", lat, 3);
        check("mis_addr", obs_addr, 12'd4);
        check("mis_err", obs_err, 1'b0);
        check("mis_rdata", obs_rdata, 32'h8001_1234);
`endif
        do_req(1'b0, 2'b11, 1'b0, 14'h010, 32'h0, 0, lat);
`ifdef MEM_ALIGN_CHECK_EN
        check("sz11_err", obs_err, 1'b1);
        check("sz11_strobes", strobe_cnt, 0);
`else
        check("sz11_err", obs_err, 1'b0);
        check("sz11_rdata", obs_rdata, 32'h8001_1234);
`endif

        // Reset during the ACCESS cycle of a store: nothing commits, no response.
        preload(8, 32'h1122_3344);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr = 14'h020; bus.req_wdata = 32'hCAFE_F00D; bus.req_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_req_ready", bus.req_ready, 1'b1);
        check("rst_mid_resp_valid", bus.resp_valid, 1'b0);
        check("rst_mid_ram", ram[8], 32'h1122_3344);
        do_req(1'b0, 2'b10, 1'b0, 14'h020, 32'h0, 0, lat);
        check("rst_mid_ld", obs_rdata, 32'h1122_3344);

        // Back-to-back stores, then loads of the merged word.
        do_req(1'b1, 2'b00, 1'b0, 14'h021, 32'h1234_56A5, 0, lat);
        check("st_b1_be", obs_be, 4'b0010);
        check("st_b1_wd", obs_wd, 32'hA5A5_A5A5);
        do_req(1'b1, 2'b01, 1'b0, 14'h022, 32'hFFFF_7766, 0, lat);
        check("st_h1_be", obs_be, 4'b1100);
        check("st_h1_wd", obs_wd, 32'h7766_7766);
        do_req(1'b0, 2'b10, 1'b0, 14'h020, 32'h0, 0, lat);
        check("ld_b2b_word", obs_rdata, 32'h7766_A544);
        do_req(1'b0, 2'b00, 1'b1, 14'h021, 32'h0, 0, lat);
        check("ld_b2b_sbyte", obs_rdata, 32'hFFFF_FFA5);
        do_req(1'b0, 2'b01, 1'b0, 14'h022, 32'h0, 0, lat);
        check("ld_b2b_uhalf", obs_rdata, 32'h0000_7766);
        do_req(1'b0, 2'b01, 1'b1, 14'h020, 32'h0, 0, lat);
        check("ld_b2b_shalf", obs_rdata, 32'hFFFF_A544);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
